// File: rtl/bus_mem_responder.sv
// Memory-side responder for the 64-bit request/response system bus: line-sized
// write and read bursts served from an internal word array, tag echoed on reads.
// Optional: BUS_MEM_CRITICAL_WORD_FIRST_EN starts read bursts at the requested word.
module bus_mem_responder #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned MEM_WORDS      = 4096,
    parameter int unsigned BURST_LEN      = 8,
    parameter int unsigned READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    output logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respcyc,
    input  logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned BW = $clog2(BURST_LEN);
    localparam int unsigned LW = $clog2(READ_LATENCY + 2);
    localparam int unsigned NW = AW - BW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        RWAIT = 2'd2,
        RRESP = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic [BW-1:0]             beat_q, beat_d;
    logic [LW-1:0]             lat_q, lat_d;
    logic [NW-1:0]             line_q, line_d;
    logic [BW-1:0]             off_q, off_d;
    logic                      reqack_q, reqack_d;
    logic                      respcyc_q, respcyc_d;
    logic [BUS_DATA_WIDTH-1:0] resp_q, resp_d;
    logic [BUS_TAG_WIDTH-1:0]  resptag_q, resptag_d;

    logic [BUS_DATA_WIDTH-1:0] mem_q [MEM_WORDS];
    logic                      mem_we_c;
    logic [AW-1:0]             mem_wa_c;
    logic [BW-1:0]             rd_beat_c;
    logic [BW-1:0]             rd_idx_c;

    logic unused_c;
    assign unused_c = ^{bus_req[BUS_DATA_WIDTH-1:AW+3], bus_req[2:0]};

    // Read word index within the line for the beat being loaded next
    always_comb begin
`ifdef BUS_MEM_CRITICAL_WORD_FIRST_EN
        rd_idx_c = BW'(rd_beat_c + off_q);
`else
        rd_idx_c = rd_beat_c;
`endif
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        lat_d     = lat_q;
        line_d    = line_q;
        off_d     = off_q;
        respcyc_d = respcyc_q;
        resp_d    = resp_q;
        resptag_d = resptag_q;
        mem_we_c  = 1'b0;
        mem_wa_c  = {line_q, beat_q};
        rd_beat_c = '0;

        case (state_q)
            IDLE: begin
                if (bus_reqcyc) begin
                    line_d = bus_req[AW+2:BW+3];
                    off_d  = bus_req[BW+2:3];
                    beat_d = '0;
                    lat_d  = '0;
                    if (bus_reqtag[BUS_TAG_WIDTH-1]) begin
                        resptag_d = bus_reqtag;
                        state_d   = RWAIT;
                    end else begin
                        state_d = WDATA;
                    end
                end
            end
            WDATA: begin
                if (bus_reqcyc) begin
                    mem_we_c = 1'b1;
                    if (beat_q == BW'(BURST_LEN - 1)) begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            RWAIT: begin
                if (lat_q == LW'(READ_LATENCY)) begin
                    rd_beat_c = '0;
                    resp_d    = mem_q[{line_q, rd_idx_c}];
                    respcyc_d = 1'b1;
                    beat_d    = '0;
                    state_d   = RRESP;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            RRESP: begin
                rd_beat_c = beat_q + BW'(1);
                if (bus_respack) begin
                    if (beat_q == BW'(BURST_LEN - 1)) begin
                        respcyc_d = 1'b0;
                        beat_d    = '0;
                        state_d   = IDLE;
                    end else begin
                        resp_d = mem_q[{line_q, rd_idx_c}];
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        reqack_d = (state_d == IDLE) || (state_d == WDATA);
    end

    // Control and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            lat_q     <= '0;
            line_q    <= '0;
            off_q     <= '0;
            reqack_q  <= 1'b1;
            respcyc_q <= 1'b0;
            resp_q    <= '0;
            resptag_q <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            lat_q     <= lat_d;
            line_q    <= line_d;
            off_q     <= off_d;
            reqack_q  <= reqack_d;
            respcyc_q <= respcyc_d;
            resp_q    <= resp_d;
            resptag_q <= resptag_d;
        end
    end

    // Backing store survives reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[mem_wa_c] <= bus_req;
        end
    end

    assign bus_reqack  = reqack_q;
    assign bus_respcyc = respcyc_q;
    assign bus_resp    = resp_q;
    assign bus_resptag = resptag_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: write/read bursts, latency, respack
// back-pressure, request stalling and reset mid-burst.
module tb_bus_mem_responder;

    localparam int unsigned LAT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_reqcyc;
    logic        bus_reqack;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_respcyc;
    logic        bus_respack;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;

    int total = 0;
    int bad   = 0;
    logic [63:0] wdata [8];
    logic [63:0] exp_beats [8];

    bus_mem_responder #(
        .BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .MEM_WORDS(4096),
        .BURST_LEN(8), .READ_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack),
        .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request beat and hold it until it transfers
    task automatic send_beat(input logic [63:0] v, input logic [12:0] tag);
        int n = 0;
        bus_reqcyc = 1'b1;
        bus_req    = v;
        bus_reqtag = tag;
        while (!bus_reqack && n < 100) begin
            tick();
            n++;
        end
        check("req_ack_wait", 64'(n < 100), 64'd1);
        tick();
        bus_reqcyc = 1'b0;
    endtask

    task automatic wr_burst(input logic [63:0] addr, input int gap);
        send_beat(addr, 13'h0000);
        for (int k = 0; k < 8; k++) begin
            repeat (gap) tick();
            send_beat(wdata[k], 13'h0000);
        end
    endtask

    // Wait for first response beat and check latency from accept edge
    task automatic wait_resp(input int exp_cycles);
        int n = 0;
        while (!bus_respcyc && n < 50) begin
            tick();
            n++;
        end
        check("first_beat_latency", 64'(n), 64'(exp_cycles));
    endtask

    task automatic rd_beats(input logic [12:0] tag, input bit toggle, input bit chk_stall);
        for (int k = 0; k < 8; k++) begin
            if (toggle) begin
                bus_respack = 1'b0;
                tick();
                check("hold_data", bus_resp, exp_beats[k]);
                check("hold_cyc", 64'(bus_respcyc), 64'd1);
            end
            bus_respack = 1'b1;
            check("beat_data", bus_resp, exp_beats[k]);
            check("beat_tag", 64'(bus_resptag), 64'(tag));
            if (chk_stall) check("stall_ack", 64'(bus_reqack), 64'd0);
            tick();
        end
        bus_respack = 1'b0;
        check("resp_end", 64'(bus_respcyc), 64'd0);
        check("idle_ack", 64'(bus_reqack), 64'd1);
    endtask

    task automatic rd_burst(input logic [63:0] addr, input logic [12:0] tag, input bit toggle);
        send_beat(addr, tag);
        wait_resp(LAT + 1);
        rd_beats(tag, toggle, 1'b0);
    endtask

    initial begin
        reset       = 1'b1;
        bus_reqcyc  = 1'b1;
        bus_req     = 64'h0;
        bus_reqtag  = 13'h0000;
        bus_respack = 1'b0;

        // Test 1: reset with reqcyc high
        #2;
        check("rst_respcyc", 64'(bus_respcyc), 64'd0);
        check("rst_reqack", 64'(bus_reqack), 64'd1);
        check("rst_resptag", 64'(bus_resptag), 64'd0);
        repeat (3) tick();
        check("rst_hold_respcyc", 64'(bus_respcyc), 64'd0);
        reset      = 1'b0;
        bus_reqcyc = 1'b0;
        tick();
        check("post_rst_respcyc", 64'(bus_respcyc), 64'd0);
        check("post_rst_reqack", 64'(bus_reqack), 64'd1);
        check("post_rst_resptag", 64'(bus_resptag), 64'd0);
        check("post_rst_resp", bus_resp, 64'd0);

        // Test 2: write line at 0x40 then read it back
        for (int k = 0; k < 8; k++) wdata[k] = 64'(8'h11 * (k + 1));
        wr_burst(64'h40, 0);
        for (int k = 0; k < 8; k++) exp_beats[k] = wdata[k];
        rd_burst(64'h40, 13'h1005, 1'b0);

        // Test 3: read with offset 3 in the line
`ifdef BUS_MEM_CRITICAL_WORD_FIRST_EN
        for (int k = 0; k < 8; k++) exp_beats[k] = wdata[(k + 3) % 8];
`else
        for (int k = 0; k < 8; k++) exp_beats[k] = wdata[k];
`endif
        rd_burst(64'h58, 13'h1abc, 1'b0);

        // Test 4: respack toggling back-pressure
        for (int k = 0; k < 8; k++) exp_beats[k] = wdata[k];
        rd_burst(64'h40, 13'h1123, 1'b1);

        // Test 5: request stalls during RRESP, then a gapped write
        for (int k = 0; k < 8; k++) wdata[k] = 64'hA5A5_0000_0000_0000 | 64'(k * 3 + 1);
        send_beat(64'h40, 13'h1007);
        wait_resp(LAT + 1);
        bus_reqcyc = 1'b1;
        bus_req    = 64'h80;
        bus_reqtag = 13'h0003;
        for (int k = 0; k < 8; k++) exp_beats[k] = 64'(8'h11 * (k + 1));
        rd_beats(13'h1007, 1'b0, 1'b1);
        tick();
        bus_reqcyc = 1'b0;
        for (int k = 0; k < 8; k++) begin
            repeat (2) tick();
            send_beat(wdata[k], 13'h0000);
        end
        for (int k = 0; k < 8; k++) exp_beats[k] = wdata[k];
        rd_burst(64'h80, 13'h1044, 1'b0);

        // Test 6: reset asserted at beat 4 of a read
        send_beat(64'h40, 13'h1066);
        wait_resp(LAT + 1);
        bus_respack = 1'b1;
        repeat (4) tick();
        check("beat4_data", bus_resp, 64'h55);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_respcyc", 64'(bus_respcyc), 64'd0);
        check("midrst_reqack", 64'(bus_reqack), 64'd1);
        check("midrst_resptag", 64'(bus_resptag), 64'd0);
        bus_respack = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("after_midrst_respcyc", 64'(bus_respcyc), 64'd0);
        rd_burst(64'h80, 13'h1fff, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
